// File: rtl/led_stream_decoder.sv
// Single-wire NRZ LED-stream receiver: measures high-pulse widths to recover GRB bits,
// assembles 24-bit pixels MSB first and flags frame gaps and protocol errors.
module led_stream_decoder #(
    parameter int unsigned HIGH_THRESH  = 60,
    parameter int unsigned MIN_HIGH     = 15,
    parameter int unsigned MAX_HIGH     = 110,
    parameter int unsigned RESET_CYCLES = 5000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        data_in,
    output logic [23:0] pixel_out,
    output logic        pixel_valid_out,
    output logic [7:0]  pixel_index_out,
    output logic        frame_done_out,
    output logic [7:0]  frame_len_out,
    output logic        err_out
);

    localparam int unsigned HW = $clog2(MAX_HIGH + 2);
    localparam int unsigned LW = $clog2(RESET_CYCLES + 1);

    localparam logic [HW-1:0] HI_SAT = HW'(MAX_HIGH + 1);
    localparam logic [HW-1:0] HI_MAX = HW'(MAX_HIGH);
    localparam logic [HW-1:0] HI_MIN = HW'(MIN_HIGH);
    localparam logic [HW-1:0] HI_THR = HW'(HIGH_THRESH);
    localparam logic [LW-1:0] LO_SAT = LW'(RESET_CYCLES);

    typedef enum logic [1:0] {
        SYNC,
        LOW,
        HIGH
    } state_t;

    state_t        state;
    logic          s1, s2, s2_d;
    logic [HW-1:0] hi_cnt;
    logic [LW-1:0] lo_cnt;
    logic [4:0]    bit_cnt;
    logic [7:0]    pix_cnt;
    logic [7:0]    index;
    logic [23:0]   shreg;
    logic          gap_taken;

    logic          rise, fall, lo_full, width_bad;
    logic [23:0]   shift_next;

    always_comb begin
        rise       = s2 & ~s2_d;
        fall       = ~s2 & s2_d;
        lo_full    = (lo_cnt == LO_SAT);
        width_bad  = (hi_cnt < HI_MIN) || (hi_cnt > HI_MAX);
        shift_next = {shreg[22:0], (hi_cnt >= HI_THR)};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= SYNC;
            s1              <= 1'b0;
            s2              <= 1'b0;
            s2_d            <= 1'b0;
            hi_cnt          <= '0;
            lo_cnt          <= '0;
            bit_cnt         <= '0;
            pix_cnt         <= '0;
            index           <= '0;
            shreg           <= '0;
            gap_taken       <= 1'b0;
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
            pixel_index_out <= '0;
            frame_done_out  <= 1'b0;
            frame_len_out   <= '0;
            err_out         <= 1'b0;
        end else begin
            s1   <= data_in;
            s2   <= s1;
            s2_d <= s2;

            pixel_valid_out <= 1'b0;
            frame_done_out  <= 1'b0;
            err_out         <= 1'b0;

            // hi_cnt restarts at 1 on the rising edge so it equals the high width at the fall
            if (rise)
                hi_cnt <= HW'(1);
            else if (s2 && hi_cnt != HI_SAT)
                hi_cnt <= hi_cnt + 1'b1;

            if (s2)
                lo_cnt <= '0;
            else if (!lo_full)
                lo_cnt <= lo_cnt + 1'b1;

            if (!lo_full)
                gap_taken <= 1'b0;

            case (state)
                SYNC: begin
                    if (lo_full) begin
                        state     <= rise ? HIGH : LOW;
                        bit_cnt   <= '0;
                        pix_cnt   <= '0;
                        index     <= '0;
                        shreg     <= '0;
                        gap_taken <= 1'b1;
                    end
                end

                LOW: begin
                    // latch event happens once per low period; a coincident rise still starts a bit
                    if (lo_full && !gap_taken) begin
                        gap_taken <= 1'b1;
                        if (bit_cnt != 5'd0) begin
                            err_out <= 1'b1;
                            bit_cnt <= '0;
                            pix_cnt <= '0;
                            index   <= '0;
                        end else if (pix_cnt != 8'd0) begin
                            frame_done_out <= 1'b1;
                            frame_len_out  <= pix_cnt;
                            pix_cnt        <= '0;
                            index          <= '0;
                        end
                    end
                    if (rise)
                        state <= HIGH;
                end

                HIGH: begin
                    if (fall) begin
                        if (width_bad) begin
                            err_out <= 1'b1;
                            state   <= SYNC;
                            bit_cnt <= '0;
                            pix_cnt <= '0;
                            index   <= '0;
                            shreg   <= '0;
                        end else begin
                            state <= LOW;
                            shreg <= shift_next;
                            if (bit_cnt == 5'd23) begin
                                pixel_out       <= shift_next;
                                pixel_valid_out <= 1'b1;
                                pixel_index_out <= index;
                                index           <= index + 8'd1;
                                if (pix_cnt != 8'hFF)
                                    pix_cnt <= pix_cnt + 8'd1;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end

                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_led_stream_decoder.sv
// Bench for led_stream_decoder: drives pulse trains and compares the decoded event stream
// with a segment-level protocol model (bits by width, frames by low-gap length).
`timescale 1ns/1ps
module tb_led_stream_decoder;

    localparam int R      = 500;
    localparam int T_MIN  = 15;
    localparam int T_MAX  = 110;
    localparam int T_THR  = 60;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        data_in;
    logic [23:0] pixel_out;
    logic        pixel_valid_out;
    logic [7:0]  pixel_index_out;
    logic        frame_done_out;
    logic [7:0]  frame_len_out;
    logic        err_out;

    led_stream_decoder #(
        .HIGH_THRESH (60),
        .MIN_HIGH    (15),
        .MAX_HIGH    (110),
        .RESET_CYCLES(R)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .data_in        (data_in),
        .pixel_out      (pixel_out),
        .pixel_valid_out(pixel_valid_out),
        .pixel_index_out(pixel_index_out),
        .frame_done_out (frame_done_out),
        .frame_len_out  (frame_len_out),
        .err_out        (err_out)
    );

    always #5 clk_in = ~clk_in;

    // kind: 0 = pixel, 1 = frame done, 2 = error
    typedef struct {
        int          kind;
        logic [23:0] data;
        logic [7:0]  idx;
    } ev_t;

    typedef struct {
        int          w;
        bit          exp_err;
        logic [23:0] exp_pixel;
    } wvec_t;

    ev_t exp_q[$];
    ev_t act_q[$];

    int  total = 0;
    int  bad   = 0;
    int  overlap_cnt = 0;
    time fall_time, last_pv_time, last_fd_time;

    // ---------------- reference model ----------------
    bit          m_synced;
    int          m_nb, m_pix, m_idx, m_lowrun;
    logic [23:0] m_acc, m_hold_pix;
    logic [7:0]  m_hold_len;

    function automatic void push_exp(int k, logic [23:0] d, logic [7:0] i);
        ev_t e;
        e.kind = k; e.data = d; e.idx = i;
        exp_q.push_back(e);
    endfunction

    function automatic void m_reset();
        m_synced = 0; m_nb = 0; m_pix = 0; m_idx = 0; m_lowrun = 0;
        m_acc = '0; m_hold_pix = '0; m_hold_len = '0;
    endfunction

    function automatic void m_pulse(int w);
        m_lowrun = 0;
        if (!m_synced) return;
        if (w < T_MIN || w > T_MAX) begin
            push_exp(2, '0, '0);
            m_synced = 0;
            m_nb = 0;
            return;
        end
        m_acc = 24'((m_acc * 2) + ((w >= T_THR) ? 1 : 0));
        m_nb++;
        if (m_nb == 24) begin
            push_exp(0, m_acc, 8'(m_idx));
            m_hold_pix = m_acc;
            m_idx = (m_idx + 1) % 256;
            m_pix = (m_pix < 255) ? m_pix + 1 : 255;
            m_nb = 0;
        end
    endfunction

    function automatic void m_low(int len);
        int prev;
        prev = m_lowrun;
        m_lowrun += len;
        if (prev < R && m_lowrun >= R) begin
            if (!m_synced) begin
                m_synced = 1; m_nb = 0; m_pix = 0; m_idx = 0;
            end else if (m_nb != 0) begin
                push_exp(2, '0, '0);
                m_nb = 0; m_pix = 0; m_idx = 0;
            end else if (m_pix > 0) begin
                push_exp(1, 24'(m_pix), '0);
                m_hold_len = 8'(m_pix);
                m_pix = 0; m_idx = 0;
            end
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk_in) begin
        ev_t e;
        if (pixel_valid_out && frame_done_out) overlap_cnt++;
        if (pixel_valid_out) begin
            e.kind = 0; e.data = pixel_out; e.idx = pixel_index_out;
            act_q.push_back(e);
            last_pv_time = $time;
        end
        if (frame_done_out) begin
            e.kind = 1; e.data = 24'(frame_len_out); e.idx = '0;
            act_q.push_back(e);
            last_fd_time = $time;
        end
        if (err_out) begin
            e.kind = 2; e.data = '0; e.idx = '0;
            act_q.push_back(e);
        end
    end

    // ---------------- drivers (called at a falling clock edge) ----------------
    task automatic drive(input logic v, input int n);
        data_in = v;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pulse(input int hi, input int lo);
        drive(1'b1, hi);
        fall_time = $time;
        drive(1'b0, lo);
        m_pulse(hi);
        m_low(lo);
    endtask

    task automatic gap(input int n);
        drive(1'b0, n);
        m_low(n);
    endtask

    task automatic std_bits(input logic [23:0] v, input int first, input int last);
        for (int b = first; b >= last; b--)
            if (v[b]) pulse(80, 45);
            else      pulse(40, 85);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, ".pixel"},  32'(pixel_out), 0);
        check({name, ".valid"},  32'(pixel_valid_out), 0);
        check({name, ".index"},  32'(pixel_index_out), 0);
        check({name, ".fdone"},  32'(frame_done_out), 0);
        check({name, ".flen"},   32'(frame_len_out), 0);
        check({name, ".err"},    32'(err_out), 0);
    endtask

    task automatic check_events(input string name);
        int n;
        check({name, ".events"}, 32'(act_q.size()), 32'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.ev%0d.kind", name, i), 32'(act_q[i].kind), 32'(exp_q[i].kind));
            check($sformatf("%s.ev%0d.data", name, i), 32'(act_q[i].data), 32'(exp_q[i].data));
            check($sformatf("%s.ev%0d.idx",  name, i), 32'(act_q[i].idx),  32'(exp_q[i].idx));
        end
        check({name, ".held_pixel"}, 32'(pixel_out), 32'(m_hold_pix));
        check({name, ".held_len"},   32'(frame_len_out), 32'(m_hold_len));
        check({name, ".overlap"},    32'(overlap_cnt), 0);
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        m_reset();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        wvec_t       tbl[8];
        logic [23:0] rest;
        logic [23:0] v;
        int          n_err;

        rest   = 24'h3C0F0F;
        tbl[0] = '{59,  1'b0, 24'h3C0F0F};
        tbl[1] = '{60,  1'b0, 24'hBC0F0F};
        tbl[2] = '{15,  1'b0, 24'h3C0F0F};
        tbl[3] = '{110, 1'b0, 24'hBC0F0F};
        tbl[4] = '{14,  1'b1, 24'h000000};
        tbl[5] = '{80,  1'b0, 24'hBC0F0F};
        tbl[6] = '{111, 1'b1, 24'h000000};
        tbl[7] = '{40,  1'b0, 24'h3C0F0F};

        data_in  = 1'b0;
        rst_n_in = 1'b0;
        m_reset();
        repeat (3) @(negedge clk_in);
        check_zero("reset");
        rst_n_in = 1'b1;

        // single pixel with latency checks on the last falling edge
        gap(600);
        std_bits(24'hFF0000, 23, 0);
        gap(600);
        check("pixel_latency", 32'(last_pv_time - fall_time), 30);
        check("latch_latency", 32'(last_fd_time - fall_time), 32'(10 * (R + 3)));
        check_events("one_pixel");

        // three-pixel frame
        std_bits(24'h123456, 23, 0);
        std_bits(24'hABCDEF, 23, 0);
        std_bits(24'h000001, 23, 0);
        gap(600);
        check_events("three_pixels");

        // width boundaries: first bit of the pixel uses the width under test
        foreach (tbl[i]) begin
            pulse(tbl[i].w, 30);
            for (int b = 22; b >= 0; b--)
                if (rest[b]) pulse(70, 20);
                else         pulse(25, 20);
            gap(600);
            if (tbl[i].exp_err) begin
                n_err = 0;
                foreach (act_q[k]) if (act_q[k].kind == 2) n_err++;
                check($sformatf("width%0d.err_count", tbl[i].w), 32'(n_err), 1);
                check($sformatf("width%0d.event_count", tbl[i].w), 32'(act_q.size()), 1);
            end else begin
                check($sformatf("width%0d.pixel", tbl[i].w),
                      (act_q.size() > 0) ? 32'(act_q[0].data) : 32'hFFFF_FFFF,
                      32'(tbl[i].exp_pixel));
            end
            check_events($sformatf("width%0d", tbl[i].w));
        end

        // truncated pixel before a gap
        std_bits(24'hA5A5A5, 23, 12);
        gap(600);
        check_events("truncated");

        // pixel too soon after reset is ignored
        do_reset();
        gap(100);
        std_bits(24'h00FF00, 23, 0);
        gap(600);
        std_bits(24'h0000FF, 23, 0);
        gap(600);
        check_events("sync_after_reset");

        // asynchronous reset in the middle of a pixel
        std_bits(24'hC3C3C3, 23, 12);
        #3 rst_n_in = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        m_reset();
        std_bits(24'hC3C3C3, 11, 0);
        gap(600);
        std_bits(24'h5A5A5A, 23, 0);
        gap(600);
        check_events("mid_pixel_reset");

        // randomized frames, some with bad widths or truncation
        for (int f = 0; f < 4; f++) begin
            int npix, bad_pos, trunc_bits;
            npix       = $urandom_range(1, 2);
            bad_pos    = (f == 2) ? $urandom_range(0, 23) : -1;
            trunc_bits = (f == 3) ? $urandom_range(1, 23) : 24;
            for (int p = 0; p < npix; p++) begin
                int nb;
                v  = 24'($urandom);
                nb = (p == npix - 1) ? trunc_bits : 24;
                for (int b = 23; b >= 24 - nb; b--) begin
                    int w;
                    if (p == 0 && b == bad_pos)
                        w = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 14) : $urandom_range(111, 130);
                    else if (v[b])
                        w = $urandom_range(60, 110);
                    else
                        w = $urandom_range(15, 59);
                    pulse(w, $urandom_range(15, 40));
                end
            end
            gap(600);
            check_events($sformatf("random%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
